log_hex_fmt: RTL and testbench

LOG_HEX_FMT -- requirements
Module: log_hex_fmt

---
 rtl/log_hex_fmt.sv | 137 +++++++++++++
 tb/tb_log_hex_fmt.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/log_hex_fmt.sv
// log_hex_fmt: turns a tagged sample into a fixed-width ASCII log line
//   "<tag>:<hex digits><spaces>\r" and hands it to a logger with a one-cycle strobe.
// The line is built one hex digit per cycle. It is held until the logger reports
// neither busy nor full. It then stays stable on log_text until the next sample is accepted.
// Build option: define LOG_HEX_FMT_DROP_EN to keep in_ready high outside reset.
// In that build, samples offered while a line is in progress are discarded and
// counted in drop_cnt, which saturates at 255.
// VAL_W must be a multiple of 4 and COUNT must be at least VAL_W/4 + 3.
module log_hex_fmt #(
   parameter int VAL_W = 16,
   parameter int COUNT = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [7:0]         in_tag,
   input  logic [VAL_W-1:0]   in_value,
   output logic [COUNT*8-1:0] log_text,
   output logic               log_stb,
   input  logic               log_busy,
   input  logic               log_full,
   output logic [7:0]         drop_cnt
);
   localparam int NDIG = VAL_W / 4;
   localparam int DW   = $clog2(NDIG + 1);
   localparam int IW   = $clog2(COUNT);
   localparam logic [DW-1:0] LAST_DIG = DW'(NDIG - 1);

   typedef enum logic [2:0] {IDLE, CONV, WAIT, SEND, GAP} state_t;

   state_t           state_reg;
   logic [VAL_W-1:0] val_reg;
   logic [DW-1:0]    dig_idx_reg;
   logic [7:0]       text_reg [COUNT];

   logic             accept;
   logic             logger_free;
   logic [3:0]       nib;
   logic [7:0]       hex_char;
   logic [IW-1:0]    dig_pos;

   // The value register is shifted left each digit, so the next nibble is always on top.
   assign nib         = val_reg[VAL_W-1 -: 4];
   assign hex_char    = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   assign dig_pos     = IW'(dig_idx_reg) + IW'(2);
   assign logger_free = !log_busy && !log_full;

`ifdef LOG_HEX_FMT_DROP_EN
   assign in_ready = !rst;
`else
   assign in_ready = (state_reg == IDLE) && !rst;
`endif

   // Only IDLE takes a sample. In the drop build, in_ready is also high in other states.
   assign accept = in_valid && in_ready && (state_reg == IDLE);

   // The strobe is masked by rst so that a reset landing on SEND abandons the line.
   assign log_stb = (state_reg == SEND) && !rst;

   // Line-formatting FSM: latch the sample, emit the digits, wait for the logger, then strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         val_reg     <= '0;
         dig_idx_reg <= '0;
         for (int i = 0; i < COUNT; i++) begin
            text_reg[i] <= 8'h20;
         end
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  val_reg     <= in_value;
                  dig_idx_reg <= '0;
                  for (int i = 0; i < COUNT; i++) begin
                     text_reg[i] <= (i == COUNT - 1) ? 8'h0D : 8'h20;
                  end
                  text_reg[0] <= in_tag;
                  text_reg[1] <= 8'h3A;
                  state_reg   <= CONV;
               end
            end
            CONV: begin
               text_reg[dig_pos] <= hex_char;
               val_reg           <= val_reg << 4;
               dig_idx_reg       <= dig_idx_reg + 1'b1;
               // If the logger is already free on the last digit, skip WAIT.
               // This lets the strobe land VAL_W/4+1 cycles after acceptance.
               if (dig_idx_reg == LAST_DIG) begin
                  state_reg <= logger_free ? SEND : WAIT;
               end
            end
            WAIT: begin
               if (logger_free) begin
                  state_reg <= SEND;
               end
            end
            SEND: begin
               state_reg <= GAP;
            end
            GAP: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

`ifdef LOG_HEX_FMT_DROP_EN
   logic [7:0] drop_cnt_reg;

   // Count samples that arrive while a line is in progress. The count saturates at 255.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt_reg <= 8'd0;
      end else if (in_valid && (state_reg != IDLE) && (drop_cnt_reg != 8'hFF)) begin
         drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end
   end

   assign drop_cnt = drop_cnt_reg;
`else
   assign drop_cnt = 8'd0;
`endif

   // Pack the line with the first character in the most significant byte.
   genvar gi;
   generate
      for (gi = 0; gi < COUNT; gi++) begin : g_text
         assign log_text[(COUNT-1-gi)*8 +: 8] = text_reg[gi];
      end
   endgenerate

endmodule

// File: tb/tb_log_hex_fmt.sv
// tb_log_hex_fmt: directed and randomized checks of log_hex_fmt against a
// behavioural model of the line format, the strobe timing and the drop count.
module tb_log_hex_fmt;
   localparam int VAL_W = 16;
   localparam int COUNT = 8;
   localparam int NDIG  = VAL_W / 4;
   localparam int MAXC  = 400;
   localparam logic [COUNT*8-1:0] SPACES = {COUNT{8'h20}};
`ifdef LOG_HEX_FMT_DROP_EN
   localparam bit DROP = 1'b1;
`else
   localparam bit DROP = 1'b0;
`endif

   logic               clk      = 1'b0;
   logic               rst      = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [7:0]         in_tag   = 8'h00;
   logic [VAL_W-1:0]   in_value = '0;
   logic [COUNT*8-1:0] log_text;
   logic               log_stb;
   logic               log_busy = 1'b0;
   logic               log_full = 1'b0;
   logic [7:0]         drop_cnt;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;
   int acc_cyc      = 0;
   int stb_seen     = 0;
   int exp_drop     = 0;
   bit prev_blk     = 1'b0;
   logic [COUNT*8-1:0] exp_q [$];
   logic [COUNT*8-1:0] mon_exp;

   log_hex_fmt #(.VAL_W(VAL_W), .COUNT(COUNT)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_tag   (in_tag),
      .in_value (in_value),
      .log_text (log_text),
      .log_stb  (log_stb),
      .log_busy (log_busy),
      .log_full (log_full),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference line: tag, ':', uppercase hex digits MSB first, spaces, CR last.
   function automatic logic [COUNT*8-1:0] exp_line(input logic [7:0] t, input logic [VAL_W-1:0] v);
      logic [COUNT*8-1:0] s;
      logic [7:0] b;
      int nib;
      s = '0;
      for (int k = 0; k < COUNT; k++) begin
         if (k == 0) b = t;
         else if (k == 1) b = 8'h3A;
         else if (k < 2 + NDIG) begin
            nib = int'(v >> (4 * (NDIG - 1 - (k - 2)))) & 15;
            b = (nib < 10) ? 8'(48 + nib) : 8'(65 + nib - 10);
         end
         else if (k == COUNT - 1) b = 8'h0D;
         else b = 8'h20;
         s = (s << 8) | {{(COUNT*8-8){1'b0}}, b};
      end
      return s;
   endfunction

   // Monitor: every strobe must carry the next expected line and follow a cycle where the logger was free.
   always @(negedge clk) begin
      if (log_stb) begin
         stb_seen++;
         check("stb_after_blocked", 64'(prev_blk), 64'd0);
         if (exp_q.size() == 0) begin
            check("spurious_stb", 64'd1, 64'd0);
         end else begin
            mon_exp = exp_q.pop_front();
            $display("[TB] line %h at cycle %0d", log_text, cyc);
            check("line_text", 64'(log_text), 64'(mon_exp));
         end
      end
      prev_blk = log_busy || log_full;
   end

   // Present one sample; called while in_ready is high, returns at the start of cycle 1.
   task automatic offer(input logic [7:0] t, input logic [VAL_W-1:0] v, input bit expect_line);
      in_valid = 1'b1;
      in_tag   = t;
      in_value = v;
      @(posedge clk);
      acc_cyc = cyc;
      #1 in_valid = 1'b0;
      if (expect_line) exp_q.push_back(exp_line(t, v));
      $display("[TB] offer tag=%h value=%h at cycle %0d", t, v, acc_cyc);
   endtask

   // Drive the logger handshake after an acceptance and time the strobe.
   // Cycle c is the c-th cycle after the acceptance.
   // The strobe is expected in the cycle after the first cycle >= NDIG that had the logger free.
   task automatic measure(input int full_lo_at, input int busy_lo_at, input bit rnd, input bit poke,
                          output int stb_at, output int ready_first);
      bit blk;
      int stb_cnt;
      int exp_stb;
      stb_at = 0; exp_stb = 0; ready_first = 0; stb_cnt = 0;
      for (int c = 1; c <= MAXC; c++) begin
         if (c > 1) begin
            @(posedge clk);
            #1;
         end
         if (rnd) begin
            log_busy = ($urandom_range(0, 2) == 0);
            log_full = ($urandom_range(0, 4) == 0);
         end else begin
            log_busy = (c < busy_lo_at);
            log_full = (c < full_lo_at);
         end
         in_valid = poke && (c == 2 || c == 3);
         if (in_valid) in_value = VAL_W'($urandom);
         blk = log_busy || log_full;
         @(negedge clk);
         if (log_stb) begin
            stb_cnt++;
            if (stb_at == 0) stb_at = c;
         end
         if (in_ready && ready_first == 0) ready_first = c;
         if (exp_stb == 0 && c >= NDIG && !blk) exp_stb = c + 1;
         if (stb_at != 0 && c == stb_at + 2) break;
      end
      in_valid = 1'b0;
      log_busy = 1'b0;
      log_full = 1'b0;
      if (poke) exp_drop = DROP ? ((exp_drop + 2 > 255) ? 255 : exp_drop + 2) : 0;
      check("stb_count", 64'(stb_cnt), 64'd1);
      check("stb_timing", 64'(stb_at), 64'(exp_stb));
      check("ready_return", 64'(ready_first), DROP ? 64'd1 : 64'(exp_stb + 2));
      check("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, r, a1, s0;
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 64'(in_ready), 64'd0);
      check("rst_stb", 64'(log_stb), 64'd0);
      check("rst_text", 64'(log_text), 64'(SPACES));
      check("rst_drop", 64'(drop_cnt), 64'd0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", 64'(in_ready), 64'd1);

      // Reference line and latency
      offer(8'h41, 16'h1F3C, 1'b1);
      measure(0, 0, 1'b0, 1'b0, s, r);
      check("line_1F3C", 64'(log_text), 64'h413A31463343200D);
      check("lat_1F3C", 64'(s), 64'd5);
      check("ready_1F3C", 64'(r), DROP ? 64'd1 : 64'd7);

      // Back to back extremes, with samples offered mid-conversion
      offer(8'h41, 16'h0000, 1'b1);
      a1 = acc_cyc;
      measure(0, 0, 1'b0, 1'b1, s, r);
      check("line_0000", 64'(log_text), 64'h413A30303030200D);
      offer(8'h41, 16'hFFFF, 1'b1);
      check("accept_spacing", 64'(acc_cyc - a1), 64'd7);
      measure(0, 0, 1'b0, 1'b0, s, r);
      check("line_FFFF", 64'(log_text), 64'h413A46464646200D);

      // Logger full for 50 cycles after conversion
      offer(8'h46, 16'hABCD, 1'b1);
      measure(55, 0, 1'b0, 1'b0, s, r);
      check("lat_full", 64'(s), 64'd56);

      // Busy overlapping into full
      offer(8'h42, 16'h0F0F, 1'b1);
      measure(30, 20, 1'b0, 1'b0, s, r);
      check("lat_busy_full", 64'(s), 64'd31);

      // Reset during conversion abandons the line
      s0 = stb_seen;
      offer(8'h41, 16'hBEEF, 1'b0);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      exp_drop = 0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("no_stb_after_rst", 64'(stb_seen - s0), 64'd0);
      check("ready_after_rst_conv", 64'(in_ready), 64'd1);
      offer(8'h41, 16'h1234, 1'b1);
      measure(0, 0, 1'b0, 1'b0, s, r);
      check("line_1234", 64'(log_text), 64'h413A31323334200D);

      // Reset coincident with SEND
      s0 = stb_seen;
      offer(8'h5A, 16'h5A5A, 1'b0);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(negedge clk);
      check("stb_rst_send", 64'(log_stb), 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      exp_drop = 0;
      @(negedge clk);
      check("text_after_rst_send", 64'(log_text), 64'(SPACES));
      repeat (8) @(posedge clk);
      @(negedge clk);
      check("no_stb_rst_send", 64'(stb_seen - s0), 64'd0);

      // Randomized samples and logger handshake
      for (int n = 0; n < 25; n++) begin
         offer(8'($urandom_range(33, 126)), VAL_W'($urandom), 1'b1);
         measure(0, 0, 1'b1, 1'($urandom_range(0, 1)), s, r);
      end

`ifdef LOG_HEX_FMT_DROP_EN
      // Drop saturation while the logger is stuck busy
      s0 = stb_seen;
      offer(8'h44, 16'hC0DE, 1'b1);
      log_busy = 1'b1;
      for (int i = 0; i < 300; i++) begin
         in_valid = 1'b1;
         in_value = VAL_W'($urandom);
         @(posedge clk); #1 in_valid = 1'b0;
         @(posedge clk); #1;
      end
      exp_drop = (exp_drop + 300 > 255) ? 255 : exp_drop + 300;
      @(negedge clk);
      check("drop_saturate", 64'(drop_cnt), 64'(exp_drop));
      check("no_stb_busy", 64'(stb_seen - s0), 64'd0);
      @(posedge clk); #1 log_busy = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("one_stb_after_busy", 64'(stb_seen - s0), 64'd1);
      check("line_C0DE", 64'(log_text), 64'h443A43304445200D);
`endif

      check("lines_pending", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
